// File: rtl/uart_rx_frame_ctrl.sv
// -----------------------------------------------------------------------------
// uart_rx_frame_ctrl
//
// Purpose:
//   Turns the byte stream from a UART receiver into framed packets of the form
//   SOF, LEN, LEN payload bytes, XOR checksum. The block hunts for SOF_BYTE,
//   validates the length and checksum, buffers the payload, and releases a
//   good frame downstream over a valid/ready stream. Bad frames are dropped
//   and flagged through frame_err / err_code.
//
// Optional feature (macro UART_RX_FRAME_TIMEOUT_EN):
//   When defined, an inter-byte gap counter aborts a frame that stalls for
//   TIMEOUT_CYCLES clocks in LEN, PAYLOAD or CHECK (err_code = 3). When not
//   defined, the block waits indefinitely and TIMEOUT_CYCLES is unused.
//
// Ports:
//   clk            in   system clock
//   rst            in   asynchronous active-high reset
//   rx_byte_valid  in   one-cycle strobe, rx_byte holds a new byte
//   rx_byte        in   received byte
//   out_valid      out  payload byte available on out_data
//   out_ready      in   consumer accepts out_data this cycle
//   out_data       out  payload byte
//   out_last       out  final payload byte of the frame
//   frame_ok       out  one-cycle pulse, frame passed checksum
//   frame_err      out  one-cycle pulse, framing error
//   err_code       out  last error cause: 0 none, 1 length, 2 checksum, 3 timeout
//   overrun        out  sticky, a byte arrived while draining
//   busy           out  high whenever the controller is not idle
// -----------------------------------------------------------------------------
module uart_rx_frame_ctrl #(
   parameter int                   WORD_SIZE      = 8,
   parameter int                   MAX_LEN        = 16,
   parameter logic [WORD_SIZE-1:0] SOF_BYTE       = 8'hA5,
   parameter int                   TIMEOUT_CYCLES = 200
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rx_byte_valid,
   input  logic [WORD_SIZE-1:0] rx_byte,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [WORD_SIZE-1:0] out_data,
   output logic                 out_last,
   output logic                 frame_ok,
   output logic                 frame_err,
   output logic [1:0]           err_code,
   output logic                 overrun,
   output logic                 busy
);

   localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam int LEN_W = $clog2(MAX_LEN + 1);
   localparam logic [WORD_SIZE-1:0] MAX_LEN_B = WORD_SIZE'(MAX_LEN);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN,
      S_PAYLOAD,
      S_CHECK,
      S_DRAIN
   } state_t;

   state_t               state_q, state_d;
   logic [LEN_W-1:0]     len_q, len_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [IDX_W-1:0]     rd_idx_q, rd_idx_d;
   logic [WORD_SIZE-1:0] acc_q, acc_d;
   logic                 frame_ok_q, frame_ok_d;
   logic                 frame_err_q, frame_err_d;
   logic [1:0]           err_code_q, err_code_d;
   logic                 overrun_q, overrun_d;
   logic                 wr_en;
   logic [IDX_W-1:0]     last_idx;

   // Payload buffer; contents are only ever read after being written in the
   // same frame, so it carries no reset.
   logic [WORD_SIZE-1:0] mem_q [MAX_LEN];

`ifdef UART_RX_FRAME_TIMEOUT_EN
   localparam int GAP_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   logic [GAP_W-1:0] gap_q, gap_d;
`endif

   // len is never 0 outside IDLE/LEN, so len-1 always fits the index width.
   assign last_idx = IDX_W'(len_q - LEN_W'(1));

   always_comb begin
      state_d     = state_q;
      len_d       = len_q;
      idx_d       = idx_q;
      rd_idx_d    = rd_idx_q;
      acc_d       = acc_q;
      frame_ok_d  = 1'b0;
      frame_err_d = 1'b0;
      err_code_d  = err_code_q;
      overrun_d   = overrun_q;
      wr_en       = 1'b0;
`ifdef UART_RX_FRAME_TIMEOUT_EN
      gap_d       = gap_q;
`endif

      case (state_q)
         S_IDLE: begin
            if (rx_byte_valid && (rx_byte == SOF_BYTE)) begin
               state_d = S_LEN;
               acc_d   = '0;
`ifdef UART_RX_FRAME_TIMEOUT_EN
               gap_d   = '0;
`endif
            end
         end

         S_LEN: begin
            if (rx_byte_valid) begin
               if ((rx_byte == '0) || (rx_byte > MAX_LEN_B)) begin
                  frame_err_d = 1'b1;
                  err_code_d  = 2'd1;
                  state_d     = S_IDLE;
               end else begin
                  len_d   = rx_byte[LEN_W-1:0];
                  acc_d   = rx_byte;
                  idx_d   = '0;
                  state_d = S_PAYLOAD;
               end
            end
         end

         S_PAYLOAD: begin
            if (rx_byte_valid) begin
               wr_en = 1'b1;
               acc_d = acc_q ^ rx_byte;
               // Hold idx on the last write so it never steps past len-1.
               if (idx_q == last_idx) begin
                  state_d = S_CHECK;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
         end

         S_CHECK: begin
            if (rx_byte_valid) begin
               if (rx_byte == acc_q) begin
                  frame_ok_d = 1'b1;
                  rd_idx_d   = '0;
                  state_d    = S_DRAIN;
               end else begin
                  frame_err_d = 1'b1;
                  err_code_d  = 2'd2;
                  state_d     = S_IDLE;
               end
            end
         end

         S_DRAIN: begin
            // Bytes arriving while draining are dropped unexamined.
            if (rx_byte_valid) begin
               overrun_d = 1'b1;
            end
            if (out_ready) begin
               if (rd_idx_q == last_idx) begin
                  state_d = S_IDLE;
               end else begin
                  rd_idx_d = rd_idx_q + IDX_W'(1);
               end
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

`ifdef UART_RX_FRAME_TIMEOUT_EN
      // Gap counter only matters while a frame is being received; a strobe
      // in these states always restarts it, so it cannot race the case above.
      if ((state_q == S_LEN) || (state_q == S_PAYLOAD) || (state_q == S_CHECK)) begin
         if (rx_byte_valid) begin
            gap_d = '0;
         end else if (gap_q == GAP_W'(TIMEOUT_CYCLES - 1)) begin
            gap_d       = '0;
            frame_err_d = 1'b1;
            err_code_d  = 2'd3;
            state_d     = S_IDLE;
         end else begin
            gap_d = gap_q + GAP_W'(1);
         end
      end
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         len_q       <= '0;
         idx_q       <= '0;
         rd_idx_q    <= '0;
         acc_q       <= '0;
         frame_ok_q  <= 1'b0;
         frame_err_q <= 1'b0;
         err_code_q  <= 2'd0;
         overrun_q   <= 1'b0;
`ifdef UART_RX_FRAME_TIMEOUT_EN
         gap_q       <= '0;
`endif
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         idx_q       <= idx_d;
         rd_idx_q    <= rd_idx_d;
         acc_q       <= acc_d;
         frame_ok_q  <= frame_ok_d;
         frame_err_q <= frame_err_d;
         err_code_q  <= err_code_d;
         overrun_q   <= overrun_d;
`ifdef UART_RX_FRAME_TIMEOUT_EN
         gap_q       <= gap_d;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[idx_q] <= rx_byte;
      end
   end

   // Outputs are decoded from registered state, so out_data/out_last stay
   // stable through a stall and are forced to zero outside DRAIN.
   assign out_valid = (state_q == S_DRAIN);
   assign out_data  = out_valid ? mem_q[rd_idx_q] : '0;
   assign out_last  = out_valid && (rd_idx_q == last_idx);
   assign frame_ok  = frame_ok_q;
   assign frame_err = frame_err_q;
   assign err_code  = err_code_q;
   assign overrun   = overrun_q;
   assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_frame_ctrl
//
// Purpose:
//   Directed, table-driven bench for uart_rx_frame_ctrl with hand-computed
//   expected outputs, plus hand-written sequences for the stalled drain with
//   overrun, an asynchronous reset mid-payload and (when
//   UART_RX_FRAME_TIMEOUT_EN is defined) the inter-byte timeout.
// -----------------------------------------------------------------------------
module tb_uart_rx_frame_ctrl;

   logic       clk;
   logic       rst;
   logic       rx_byte_valid;
   logic [7:0] rx_byte;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic       out_last;
   logic       frame_ok;
   logic       frame_err;
   logic [1:0] err_code;
   logic       overrun;
   logic       busy;

   int n_cmp;
   int n_bad;

   uart_rx_frame_ctrl #(
      .WORD_SIZE      (8),
      .MAX_LEN        (16),
      .SOF_BYTE       (8'hA5),
      .TIMEOUT_CYCLES (200)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .rx_byte_valid (rx_byte_valid),
      .rx_byte       (rx_byte),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_data      (out_data),
      .out_last      (out_last),
      .frame_ok      (frame_ok),
      .frame_err     (frame_err),
      .err_code      (err_code),
      .overrun       (overrun),
      .busy          (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

   // One vector = inputs held for one cycle plus the outputs expected in that
   // same cycle (sampled at the falling edge, before the edge consumes them).
   typedef struct {
      logic       v;
      logic [7:0] b;
      logic       rdy;
      logic       ov;
      logic [7:0] od;
      logic       ol;
      logic       ok;
      logic       er;
      logic [1:0] ec;
      logic       bsy;
      logic       ovr;
   } vec_t;

   vec_t tbl [$];

   function automatic vec_t mk(input logic v, input logic [7:0] b, input logic rdy,
                               input logic ov, input logic [7:0] od, input logic ol,
                               input logic ok, input logic er, input logic [1:0] ec,
                               input logic bsy, input logic ovr);
      vec_t t;
      t.v = v; t.b = b; t.rdy = rdy; t.ov = ov; t.od = od; t.ol = ol;
      t.ok = ok; t.er = er; t.ec = ec; t.bsy = bsy; t.ovr = ovr;
      return t;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic set_in(input logic v, input logic [7:0] b, input logic r);
      rx_byte_valid = v;
      rx_byte       = b;
      out_ready     = r;
   endtask

   // Called at posedge+1: presents one strobe and moves to the next posedge+1.
   task automatic send(input logic [7:0] b, input logic r);
      set_in(1'b1, b, r);
      @(posedge clk);
      #1;
   endtask

   task automatic idle_cycle(input logic r);
      set_in(1'b0, 8'h00, r);
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      rst   = 1'b1;
      set_in(1'b0, 8'h00, 1'b0);
      #1;
      chk("reset.out_valid", out_valid, 0);
      chk("reset.out_data",  out_data,  0);
      chk("reset.out_last",  out_last,  0);
      chk("reset.frame_ok",  frame_ok,  0);
      chk("reset.frame_err", frame_err, 0);
      chk("reset.err_code",  err_code,  0);
      chk("reset.overrun",   overrun,   0);
      chk("reset.busy",      busy,      0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      // Good frame A5 03 11 22 33 03 (03^11^22^33 = 03), consumer always ready.
      tbl.push_back(mk(1, 8'hA5, 1, 0, 8'h00, 0, 0, 0, 2'd0, 0, 0));
      tbl.push_back(mk(1, 8'h03, 1, 0, 8'h00, 0, 0, 0, 2'd0, 1, 0));
      tbl.push_back(mk(1, 8'h11, 1, 0, 8'h00, 0, 0, 0, 2'd0, 1, 0));
      tbl.push_back(mk(1, 8'h22, 1, 0, 8'h00, 0, 0, 0, 2'd0, 1, 0));
      tbl.push_back(mk(1, 8'h33, 1, 0, 8'h00, 0, 0, 0, 2'd0, 1, 0));
      tbl.push_back(mk(1, 8'h03, 1, 0, 8'h00, 0, 0, 0, 2'd0, 1, 0));
      tbl.push_back(mk(0, 8'h00, 1, 1, 8'h11, 0, 1, 0, 2'd0, 1, 0));
      tbl.push_back(mk(0, 8'h00, 1, 1, 8'h22, 0, 0, 0, 2'd0, 1, 0));
      tbl.push_back(mk(0, 8'h00, 1, 1, 8'h33, 1, 0, 0, 2'd0, 1, 0));
      tbl.push_back(mk(0, 8'h00, 1, 0, 8'h00, 0, 0, 0, 2'd0, 0, 0));
      // Same frame, wrong checksum 04.
      tbl.push_back(mk(1, 8'hA5, 1, 0, 8'h00, 0, 0, 0, 2'd0, 0, 0));
      tbl.push_back(mk(1, 8'h03, 1, 0, 8'h00, 0, 0, 0, 2'd0, 1, 0));
      tbl.push_back(mk(1, 8'h11, 1, 0, 8'h00, 0, 0, 0, 2'd0, 1, 0));
      tbl.push_back(mk(1, 8'h22, 1, 0, 8'h00, 0, 0, 0, 2'd0, 1, 0));
      tbl.push_back(mk(1, 8'h33, 1, 0, 8'h00, 0, 0, 0, 2'd0, 1, 0));
      tbl.push_back(mk(1, 8'h04, 1, 0, 8'h00, 0, 0, 0, 2'd0, 1, 0));
      tbl.push_back(mk(0, 8'h00, 1, 0, 8'h00, 0, 0, 1, 2'd2, 0, 0));
      tbl.push_back(mk(0, 8'h00, 1, 0, 8'h00, 0, 0, 0, 2'd2, 0, 0));
      // Bad lengths: 00, then 11 (17 > MAX_LEN).
      tbl.push_back(mk(1, 8'hA5, 1, 0, 8'h00, 0, 0, 0, 2'd2, 0, 0));
      tbl.push_back(mk(1, 8'h00, 1, 0, 8'h00, 0, 0, 0, 2'd2, 1, 0));
      tbl.push_back(mk(0, 8'h00, 1, 0, 8'h00, 0, 0, 1, 2'd1, 0, 0));
      tbl.push_back(mk(1, 8'hA5, 1, 0, 8'h00, 0, 0, 0, 2'd1, 0, 0));
      tbl.push_back(mk(1, 8'h11, 1, 0, 8'h00, 0, 0, 0, 2'd1, 1, 0));
      tbl.push_back(mk(0, 8'h00, 1, 0, 8'h00, 0, 0, 1, 2'd1, 0, 0));
      tbl.push_back(mk(0, 8'h00, 1, 0, 8'h00, 0, 0, 0, 2'd1, 0, 0));
      // Noise then single-byte frame A5 01 5A 5B (01^5A = 5B); err_code held.
      tbl.push_back(mk(1, 8'h00, 1, 0, 8'h00, 0, 0, 0, 2'd1, 0, 0));
      tbl.push_back(mk(1, 8'hFF, 1, 0, 8'h00, 0, 0, 0, 2'd1, 0, 0));
      tbl.push_back(mk(1, 8'hA5, 1, 0, 8'h00, 0, 0, 0, 2'd1, 0, 0));
      tbl.push_back(mk(1, 8'h01, 1, 0, 8'h00, 0, 0, 0, 2'd1, 1, 0));
      tbl.push_back(mk(1, 8'h5A, 1, 0, 8'h00, 0, 0, 0, 2'd1, 1, 0));
      tbl.push_back(mk(1, 8'h5B, 1, 0, 8'h00, 0, 0, 0, 2'd1, 1, 0));
      tbl.push_back(mk(0, 8'h00, 1, 1, 8'h5A, 1, 1, 0, 2'd1, 1, 0));
      tbl.push_back(mk(0, 8'h00, 1, 0, 8'h00, 0, 0, 0, 2'd1, 0, 0));

      foreach (tbl[i]) begin
         set_in(tbl[i].v, tbl[i].b, tbl[i].rdy);
         #4;
         chk($sformatf("vec%0d.out_valid", i), out_valid, tbl[i].ov);
         if (tbl[i].ov) chk($sformatf("vec%0d.out_data", i), out_data, tbl[i].od);
         chk($sformatf("vec%0d.out_last", i),  out_last,  tbl[i].ol);
         chk($sformatf("vec%0d.frame_ok", i),  frame_ok,  tbl[i].ok);
         chk($sformatf("vec%0d.frame_err", i), frame_err, tbl[i].er);
         chk($sformatf("vec%0d.err_code", i),  err_code,  tbl[i].ec);
         chk($sformatf("vec%0d.busy", i),      busy,      tbl[i].bsy);
         chk($sformatf("vec%0d.overrun", i),   overrun,   tbl[i].ovr);
         @(posedge clk);
         #1;
      end

      // Stalled drain: A5 02 AA 55 FD, ready low 5 cycles, 7E arrives mid-stall.
      send(8'hA5, 1'b0);
      send(8'h02, 1'b0);
      send(8'hAA, 1'b0);
      send(8'h55, 1'b0);
      send(8'hFD, 1'b0);
      for (int i = 0; i < 5; i++) begin
         set_in(i == 2, 8'h7E, 1'b0);
         #4;
         chk($sformatf("stall%0d.out_valid", i), out_valid, 1);
         chk($sformatf("stall%0d.out_data", i),  out_data,  8'hAA);
         chk($sformatf("stall%0d.out_last", i),  out_last,  0);
         chk($sformatf("stall%0d.frame_ok", i),  frame_ok,  (i == 0));
         chk($sformatf("stall%0d.overrun", i),   overrun,   (i > 2));
         @(posedge clk);
         #1;
      end
      set_in(1'b0, 8'h00, 1'b1);
      #4;
      chk("drain0.out_data", out_data, 8'hAA);
      chk("drain0.out_last", out_last, 0);
      @(posedge clk);
      #5;
      chk("drain1.out_valid", out_valid, 1);
      chk("drain1.out_data",  out_data,  8'h55);
      chk("drain1.out_last",  out_last,  1);
      @(posedge clk);
      #5;
      chk("drain_end.out_valid", out_valid, 0);
      chk("drain_end.busy",      busy,      0);
      chk("drain_end.overrun",   overrun,   1);
      chk("drain_end.err_code",  err_code,  1);
      @(posedge clk);
      #1;

      // Asynchronous reset in the middle of a payload.
      send(8'hA5, 1'b1);
      send(8'h03, 1'b1);
      send(8'h11, 1'b1);
      set_in(1'b1, 8'h22, 1'b1);
      #2;
      rst = 1'b1;
      #1;
      chk("midrst.busy",      busy,      0);
      chk("midrst.out_valid", out_valid, 0);
      chk("midrst.out_last",  out_last,  0);
      chk("midrst.out_data",  out_data,  0);
      chk("midrst.frame_ok",  frame_ok,  0);
      chk("midrst.frame_err", frame_err, 0);
      chk("midrst.err_code",  err_code,  0);
      chk("midrst.overrun",   overrun,   0);
      set_in(1'b0, 8'h00, 1'b1);
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         idle_cycle(1'b1);
         chk($sformatf("postrst%0d.pulses", i), {frame_ok, frame_err, busy}, 3'b000);
      end
      // Recovery frame A5 01 42 43.
      send(8'hA5, 1'b1);
      send(8'h01, 1'b1);
      send(8'h42, 1'b1);
      send(8'h43, 1'b1);
      chk("recover.out_valid", out_valid, 1);
      chk("recover.out_data",  out_data,  8'h42);
      chk("recover.out_last",  out_last,  1);
      chk("recover.frame_ok",  frame_ok,  1);
      idle_cycle(1'b1);
      chk("recover.idle", {out_valid, busy}, 2'b00);

`ifdef UART_RX_FRAME_TIMEOUT_EN
      // Timeout: A5 03 11 then silence; frame_err 200 cycles after the 11 edge.
      send(8'hA5, 1'b1);
      send(8'h03, 1'b1);
      send(8'h11, 1'b1);
      set_in(1'b0, 8'h00, 1'b1);
      for (int k = 1; k <= 200; k++) begin
         @(posedge clk);
         #1;
         if (frame_err !== (k == 200)) chk($sformatf("timeout.k%0d", k), frame_err, (k == 200));
      end
      chk("timeout.frame_err", frame_err, 1);
      chk("timeout.err_code",  err_code,  3);
      chk("timeout.busy",      busy,      0);
      send(8'hA5, 1'b1);
      send(8'h01, 1'b1);
      send(8'h42, 1'b1);
      send(8'h43, 1'b1);
      chk("timeout_recover.out_data", out_data, 8'h42);
      chk("timeout_recover.frame_ok", frame_ok, 1);
      idle_cycle(1'b1);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
